param_control_unit: RTL

- Parametrised multi-cycle control FSM for the microprocessor datapath.
- Accepts one instruction per valid/ready handshake and decodes it.
- Sequences register-file reads, ALU start/done handshakes and register writeback.
- Adds illegal-opcode detection, HALT, an ALU timeout and an optional retired-instruction counter.

---
 rtl/param_control_unit_if.sv | 45 ++++
 rtl/param_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/param_control_unit_if.sv
// param_control_unit_if
//   Bundles the instruction handshake, register-file port and ALU handshake
//   of param_control_unit.
//   Handshake: an instruction transfers on a rising clk edge where
//   instr_valid and instr_ready are both 1. The control unit raises
//   instr_ready only in FETCH. The source keeps instr stable while
//   instr_valid is high and instr_ready is low.
//   master : control-unit side (drives reg/ALU controls, consumes instr)
//   slave  : environment side (instruction source, register file, ALU)
//   dbg_state exposes the FSM state encoding for observation.
interface param_control_unit_if #(
  parameter int OPC_W = 8,
  parameter int OPD_W = 8
);
  logic                     instr_valid;
  logic                     instr_ready;
  logic [OPC_W+2*OPD_W-1:0] instr;
  logic [OPD_W-1:0]         reg_rd_data;
  logic [OPD_W-1:0]         alu_result;
  logic                     alu_done;
  logic                     reg_re;
  logic                     reg_we;
  logic [OPD_W-1:0]         adr_1;
  logic [OPD_W-1:0]         adr_2;
  logic [OPD_W-1:0]         adr_3;
  logic [OPD_W-1:0]         write_data;
  logic [OPC_W-1:0]         alu_sel;
  logic                     alu_start;
  logic                     illegal_op;
  logic                     alu_timeout;
  logic                     halted;
  logic [2:0]               dbg_state;

  modport master (
    input  instr_valid, instr, reg_rd_data, alu_result, alu_done,
    output instr_ready, reg_re, reg_we, adr_1, adr_2, adr_3, write_data,
           alu_sel, alu_start, illegal_op, alu_timeout, halted, dbg_state
  );

  modport slave (
    output instr_valid, instr, reg_rd_data, alu_result, alu_done,
    input  instr_ready, reg_re, reg_we, adr_1, adr_2, adr_3, write_data,
           alu_sel, alu_start, illegal_op, alu_timeout, halted, dbg_state
  );
endinterface

// File: rtl/param_control_unit.sv
// param_control_unit
//   Multi-cycle control FSM: FETCH -> DECODE -> (EXEC -> (WAIT) ->) WB,
//   plus HALT. Sequences register reads, the ALU start/done handshake and
//   writeback. Every output is a flop loaded from the next-state decode, so
//   it is valid during the cycle the FSM spends in the corresponding state.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : param_control_unit_if.master (handshake, reg file, ALU)
//   retired_cnt: retired-instruction count (only with CU_PERF_CNT_EN)
// Optional feature macro: CU_PERF_CNT_EN (saturating retired counter).
module param_control_unit #(
  parameter int OPC_W       = 8,
  parameter int OPD_W       = 8,
  parameter int C_ADDR      = 2,
  parameter int ALU_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  param_control_unit_if.master bus
`ifdef CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_STR, K_MOV, K_BIN, K_UN, K_HALT, K_ILL
  } kind_t;

  localparam int TO_W = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;

  state_t           state;
  logic [OPC_W-1:0] opc_q;
  logic [OPD_W-1:0] op1_q;
  logic [OPD_W-1:0] op2_q;
  logic [TO_W-1:0]  wait_cnt;
  kind_t            kind;
  logic             to_hit;

  function automatic kind_t classify(input logic [OPC_W-1:0] opc);
    kind_t k;
    k = K_ILL;
    if (opc == OPC_W'(8'h00))                                 k = K_NOP;
    else if (opc == OPC_W'(8'h01))                            k = K_STR;
    else if (opc == OPC_W'(8'h02))                            k = K_MOV;
    else if (opc >= OPC_W'(8'h03) && opc <= OPC_W'(8'h09))    k = K_BIN;
    else if (opc >= OPC_W'(8'h0C) && opc <= OPC_W'(8'h0F))    k = K_BIN;
    else if (opc == OPC_W'(8'h0A) || opc == OPC_W'(8'h0B))    k = K_UN;
    else if (opc >= OPC_W'(8'h10) && opc <= OPC_W'(8'h17))    k = K_UN;
    else if (opc == OPC_W'(8'h1F))                            k = K_HALT;
    return k;
  endfunction

  assign kind          = classify(opc_q);
  // wait_cnt holds the number of WAIT edges already seen without alu_done.
  assign to_hit        = (ALU_TIMEOUT != 0) && (wait_cnt == TO_W'(ALU_TIMEOUT - 1));
  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_FETCH;
      opc_q           <= '0;
      op1_q           <= '0;
      op2_q           <= '0;
      wait_cnt        <= '0;
      bus.instr_ready <= 1'b0;
      bus.reg_re      <= 1'b0;
      bus.reg_we      <= 1'b0;
      bus.adr_1       <= '0;
      bus.adr_2       <= '0;
      bus.adr_3       <= '0;
      bus.write_data  <= '0;
      bus.alu_sel     <= '0;
      bus.alu_start   <= 1'b0;
      bus.illegal_op  <= 1'b0;
      bus.alu_timeout <= 1'b0;
      bus.halted      <= 1'b0;
    end else begin
      // Outputs default to 0; each branch sets what its next state shows.
      bus.instr_ready <= 1'b0;
      bus.reg_re      <= 1'b0;
      bus.reg_we      <= 1'b0;
      bus.adr_1       <= '0;
      bus.adr_2       <= '0;
      bus.adr_3       <= '0;
      bus.write_data  <= '0;
      bus.alu_sel     <= '0;
      bus.alu_start   <= 1'b0;
      bus.illegal_op  <= 1'b0;
      bus.alu_timeout <= 1'b0;
      bus.halted      <= 1'b0;
      case (state)
        S_FETCH: begin
          if (bus.instr_valid && bus.instr_ready) begin
            opc_q <= bus.instr[OPC_W+2*OPD_W-1 -: OPC_W];
            op1_q <= bus.instr[2*OPD_W-1 -: OPD_W];
            op2_q <= bus.instr[OPD_W-1:0];
            state <= S_DECODE;
          end else begin
            state           <= S_FETCH;
            bus.instr_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          case (kind)
            K_NOP: begin
              state           <= S_FETCH;
              bus.instr_ready <= 1'b1;
            end
            K_STR: begin
              state          <= S_WB;
              bus.reg_we     <= 1'b1;
              bus.adr_3      <= op1_q;
              bus.write_data <= op2_q;
            end
            K_MOV: begin
              state      <= S_EXEC;
              bus.reg_re <= 1'b1;
              bus.adr_1  <= op2_q;
            end
            K_BIN, K_UN: begin
              state         <= S_EXEC;
              bus.reg_re    <= 1'b1;
              bus.adr_1     <= op1_q;
              bus.adr_2     <= (kind == K_BIN) ? op2_q : '0;
              bus.alu_start <= 1'b1;
              bus.alu_sel   <= opc_q;
            end
            K_HALT: begin
              state      <= S_HALT;
              bus.halted <= 1'b1;
            end
            default: begin
              state           <= S_FETCH;
              bus.instr_ready <= 1'b1;
              bus.illegal_op  <= 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          if (kind == K_MOV) begin
            state          <= S_WB;
            bus.reg_we     <= 1'b1;
            bus.adr_3      <= op1_q;
            bus.write_data <= bus.reg_rd_data;
          end else begin
            state       <= S_WAIT;
            bus.reg_re  <= 1'b1;
            bus.adr_1   <= bus.adr_1;
            bus.adr_2   <= bus.adr_2;
            bus.alu_sel <= bus.alu_sel;
            wait_cnt    <= '0;
          end
        end
        S_WAIT: begin
          // alu_done is checked before the timeout so it wins a tie.
          if (bus.alu_done) begin
            state          <= S_WB;
            bus.reg_we     <= 1'b1;
            bus.adr_3      <= OPD_W'(C_ADDR);
            bus.write_data <= bus.alu_result;
          end else if (to_hit) begin
            state           <= S_FETCH;
            bus.instr_ready <= 1'b1;
            bus.alu_timeout <= 1'b1;
          end else begin
            state       <= S_WAIT;
            bus.reg_re  <= 1'b1;
            bus.adr_1   <= bus.adr_1;
            bus.adr_2   <= bus.adr_2;
            bus.alu_sel <= bus.alu_sel;
            wait_cnt    <= wait_cnt + TO_W'(1);
          end
        end
        S_WB: begin
          state           <= S_FETCH;
          bus.instr_ready <= 1'b1;
        end
        S_HALT: begin
          state      <= S_HALT;
          bus.halted <= 1'b1;
        end
        default: begin
          state           <= S_FETCH;
          bus.instr_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CU_PERF_CNT_EN
  // Retirement happens on the FETCH entry from WB or from a decoded NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if ((state == S_WB) || (state == S_DECODE && kind == K_NOP)) begin
      if (retired_cnt != {CNT_W{1'b1}}) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
